// File: rtl/ssenc_scan.sv
// Seven-segment bus monitor: decodes each stable multiplexed digit back to hex,
// keeps a per-digit snapshot and reports changes on a single-entry valid/ready slot.
module ssenc_scan #(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NDIG-1:0]         sel_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [$clog2(NDIG)-1:0] out_idx,
    output logic [3:0]              out_val,
    output logic                    out_blank,
    output logic                    out_err,
    output logic                    out_ovf,
    output logic [4*NDIG-1:0]       digits,
    output logic [NDIG-1:0]         digits_ok
);

    localparam int IW = $clog2(NDIG);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t            state_reg;
    logic [NDIG+6:0]   samp_reg;
    logic [7:0]        cnt_reg;

    logic              onehot;
    logic              match;
    logic              cap;
    logic              changed;
    logic              ev;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_val;
    logic              dec_blank;
    logic              dec_err;

    logic [4*NDIG-1:0] st_val;
    logic [NDIG-1:0]   st_blank;
    logic [NDIG-1:0]   st_err;
    logic [NDIG-1:0]   st_seen;

    assign onehot = $onehot(sel_in);
    assign match  = ({sel_in, seg_in} == samp_reg) && onehot;
    // Capture exactly once, on the edge the run length reaches STABLE.
    assign cap    = (state_reg == SETTLE) && match && (cnt_reg == 8'(STABLE - 1));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_in[i]) idx = IW'(i);
        end
    end

    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h67: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign changed = !st_seen[idx]
                  || (st_val[{idx, 2'b00} +: 4] != dec_val)
                  || (st_blank[idx] != dec_blank)
                  || (st_err[idx] != dec_err);
    assign ev = cap && changed;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            logic [3:0] val_reg;
            logic       blank_reg;
            logic       err_reg;
            logic       seen_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_reg   <= 4'h0;
                    blank_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    seen_reg  <= 1'b0;
                end else if (cap && (idx == IW'(gi))) begin
                    val_reg   <= dec_val;
                    blank_reg <= dec_blank;
                    err_reg   <= dec_err;
                    seen_reg  <= 1'b1;
                end
            end

            assign st_val[4*gi +: 4] = val_reg;
            assign st_blank[gi]      = blank_reg;
            assign st_err[gi]        = err_reg;
            assign st_seen[gi]       = seen_reg;
        end
    endgenerate

    assign digits    = st_val;
    assign digits_ok = st_seen & ~st_blank & ~st_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SETTLE;
            samp_reg  <= '0;
            cnt_reg   <= 8'd0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_val   <= 4'h0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            samp_reg <= {sel_in, seg_in};

            if (!match) begin
                cnt_reg <= 8'd0;
            end else if (cnt_reg != 8'(STABLE)) begin
                cnt_reg <= cnt_reg + 8'd1;
            end

            case (state_reg)
                SETTLE:  if (cap) state_reg <= LOCKED;
                LOCKED:  if (!match) state_reg <= SETTLE;
                default: state_reg <= SETTLE;
            endcase

            // A slot being accepted this edge is free for the new event.
            if (ev) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_idx   <= idx;
                    out_val   <= dec_val;
                    out_blank <= dec_blank;
                    out_err   <= dec_err;
                end else begin
                    out_ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
